// File: rtl/phase_seq_arbiter.sv
// rtl/phase_seq_arbiter.sv - round-robin arbiter with grant/cmd/wait/end transaction sequencer
// Optional embedded checks: define PHASE_SEQ_ASSERT_EN.
module phase_seq_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    abort,
  input  logic                    rsp_ok,
  input  logic                    rsp_err,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    gnt_vld,
  output logic                    cmd_vld,
  output logic                    done,
  output logic                    fault,
  output logic                    timeout,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    CMD   = 3'd2,
    WAIT  = 3'd3,
    END   = 3'd4
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  cnt;
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] next_ptr;

  // First set request at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // gnt_id doubles as the winner register, so the pointer advances past it.
  assign next_ptr = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      cnt     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
      cmd_vld <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt_vld <= 1'b0;
      cmd_vld <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      timeout <= 1'b0;
      if (state != IDLE && abort) begin
        state  <= IDLE;
        gnt    <= '0;
        gnt_id <= '0;
        busy   <= 1'b0;
        rr_ptr <= next_ptr;
      end else begin
        case (state)
          IDLE: begin
            if (found && !abort) begin
              state   <= GRANT;
              gnt     <= NREQ'(1) << pick;
              gnt_id  <= pick;
              gnt_vld <= 1'b1;
              busy    <= 1'b1;
            end
          end
          GRANT: begin
            state   <= CMD;
            cmd_vld <= 1'b1;
          end
          CMD: begin
            state <= WAIT;
            cnt   <= '0;
          end
          WAIT: begin
            if (rsp_err) begin
              state <= END;
              fault <= 1'b1;
            end else if (rsp_ok) begin
              state <= END;
              done  <= 1'b1;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
              state   <= END;
              fault   <= 1'b1;
              timeout <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          END: begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
          default: begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PHASE_SEQ_ASSERT_EN
  a_gnt_then_cmd: assert property (@(posedge clk) disable iff (!rst_n || abort)
    gnt_vld |=> cmd_vld);
  a_cmd_completes: assert property (@(posedge clk) disable iff (!rst_n || abort)
    cmd_vld |=> (state == WAIT && (rsp_ok || rsp_err || cnt == CW'(TIMEOUT - 1)))[->1]
                ##1 (done || fault));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n || abort)
    $onehot0(gnt));
  a_done_fault_excl: assert property (@(posedge clk) disable iff (!rst_n || abort)
    !(done && fault));
`else
`endif

endmodule

// File: doc/phase_seq_arbiter.md
Name: phase_seq_arbiter

Overview:
Round-robin arbiter and transaction sequencer for a shared command resource. It grants one of NREQ requesters and drives a fixed grant → command → response-wait → completion sequence. Completion ends in either a done pulse or a fault pulse. The block sits between the requesting agents and the shared resource and is the sole owner of that resource's command handshake.

Parameters:
NREQ, 4, number of requesters; legal range 2..16.
TIMEOUT, 15, maximum number of cycles spent in WAIT before a fault; legal range 1..255.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  NREQ  per-requester request level.
abort  input  1  synchronous abort; highest priority.
rsp_ok  input  1  resource reports success.
rsp_err  input  1  resource reports error.
gnt  output  NREQ  one-hot grant, held for the whole transaction.
gnt_id  output  $clog2(NREQ)  binary index of the granted requester.
gnt_vld  output  1  one-cycle pulse in the GRANT state.
cmd_vld  output  1  one-cycle pulse in the CMD state.
done  output  1  one-cycle success pulse.
fault  output  1  one-cycle failure pulse.
timeout  output  1  qualifies fault; 1 means the fault was caused by timeout.
busy  output  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE; rr_ptr = 0; WAIT counter = 0.
  - All outputs are 0.
- Outputs: every output is registered (Moore), decoded from state and the winner register.
- States: IDLE → GRANT → CMD → WAIT → END → IDLE.
- IDLE:
  - If any req bit is set and abort=0, select the first set bit searching upward from rr_ptr, wrapping at NREQ.
  - Latch the winner and go to GRANT.
  - Latency: req sampled at edge k; gnt and gnt_vld high in cycle k+1.
- GRANT: lasts 1 cycle; gnt_vld=1; then CMD.
- CMD: lasts 1 cycle; cmd_vld=1; then WAIT with the counter cleared.
- WAIT:
  - rsp_ok or rsp_err sampled high → END.
  - If both are high in the same cycle, rsp_err wins.
  - If no response arrives and counter == TIMEOUT-1 → END with the timeout flag set. WAIT therefore lasts at most TIMEOUT cycles.
  - Otherwise the counter increments.
- END:
  - Lasts 1 cycle.
  - done=1 on success, or fault=1 on error/timeout; timeout=1 only for the timeout case.
  - rr_ptr = (winner+1) mod NREQ; then IDLE.
- Hold rules:
  - gnt and gnt_id are held constant from GRANT through END inclusive, and are 0 in IDLE.
  - busy = 1 in GRANT, CMD, WAIT and END.
- Ignored inputs:
  - rsp_ok and rsp_err are ignored outside WAIT.
  - A requester dropping req mid-transaction is ignored; the transaction still completes.
  - New requests are ignored until the state returns to IDLE.
- Abort:
  - abort=1 in any non-IDLE state → IDLE on the next edge.
  - No done or fault pulse is produced; gnt clears.
  - rr_ptr advances past the aborted winner.
  - abort=1 in IDLE blocks arbitration for that cycle.
- Throughput: minimum 5 cycles per transaction (GRANT, CMD, one WAIT cycle, END, IDLE). Back-to-back transactions always have at least one IDLE cycle between them.
- Fairness: with all requesters asserting continuously, grants rotate strictly 0,1,…,NREQ-1,0.
- Reset mid-transaction: immediate return to the reset values, including rr_ptr = 0.

Optional Feature:
PHASE_SEQ_ASSERT_EN: when defined, the module embeds concurrent assertions clocked on posedge clk, each with disable iff (!rst_n || abort):
- gnt_vld |=> cmd_vld.
- cmd_vld |=> (rsp_ok || rsp_err || timeout-window)[->1] ##1 (done || fault).
- $onehot0(gnt).
- !(done && fault).
When the macro is not defined, no assertion code is compiled and functional behaviour is identical.

Test Plan:
- NREQ=4, TIMEOUT=15. req=4'b0100 at cycle 0, rsp_ok at cycle 3 → gnt_vld with gnt=4'b0100, gnt_id=2 at cycle 1; cmd_vld at 2; done at 4; busy=0 at 5.
- req=4'b1111 held for 4 transactions with immediate rsp_ok → gnt_id sequence 0,1,2,3; each done is 5 cycles after the previous one.
- No response after cmd_vld at cycle 2 → WAIT cycles 3..17; fault=1 and timeout=1 at cycle 18.
- rsp_ok=1 and rsp_err=1 in the same WAIT cycle → fault=1, timeout=0, done=0.
- abort=1 in CMD with gnt_id=1 → IDLE next cycle, gnt=0, no done or fault; with req=4'b1111 the next gnt_id is 2.
- rst_n low during WAIT → all outputs 0 immediately; the next req=4'b1111 grants gnt_id=0.
